// File: rtl/unidade_de_execucao_pkg.sv
// Shared definitions for the execution sequencer: opcodes, instruction field
// positions, FSM states and default widths.
package unidade_de_execucao_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 4;

    localparam int unsigned OPC_LSB   = 28;
    localparam int unsigned RD_LSB    = 24;
    localparam int unsigned RS1_LSB   = 20;
    localparam int unsigned RS2_LSB   = 16;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned IMM_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SLL  = 4'h6,
        OP_SRL  = 4'h7,
        OP_ADDI = 4'h8,
        OP_LUI  = 4'h9,
        OP_SLT  = 4'hA
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    // Every legal opcode except NOP produces a register result.
    function automatic logic writes_rd(input logic [3:0] op);
        return (op != OP_NOP) && (op <= OP_SLT);
    endfunction

endpackage

// File: rtl/unidade_de_execucao_ula.sv
// Combinational ALU: result, signed overflow for ADD/SUB/ADDI, and illegal
// opcode flag.
module ula
    import unidade_de_execucao_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [3:0]            opcode_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [IMM_WIDTH-1:0]  imm_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  overflow_o,
    output logic                  illegal_o
);

    localparam int unsigned MSB = DATA_WIDTH - 1;
    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] imm_zext;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] sum_imm;

    assign imm_sext = {{(DATA_WIDTH-IMM_WIDTH){imm_i[IMM_WIDTH-1]}}, imm_i};
    assign imm_zext = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm_i};
    assign sum      = a_i + b_i;
    assign diff     = a_i - b_i;
    assign sum_imm  = a_i + imm_sext;

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_i)
            OP_NOP: ;
            OP_ADD: begin
                result_o   = sum;
                overflow_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                result_o   = diff;
                overflow_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLL:  result_o = a_i << b_i[SHW-1:0];
            OP_SRL:  result_o = a_i >> b_i[SHW-1:0];
            OP_ADDI: begin
                result_o   = sum_imm;
                overflow_o = (a_i[MSB] == imm_sext[MSB]) && (sum_imm[MSB] != a_i[MSB]);
            end
            OP_LUI:  result_o = imm_zext << IMM_WIDTH;
            OP_SLT:  result_o[0] = ($signed(a_i) < $signed(b_i));
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_de_execucao.sv
// Four-state issue/read/execute/writeback sequencer driving a 16x32 register
// bank with registered read outputs.
module unidade_de_execucao
    import unidade_de_execucao_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  Clock_in,
    input  logic                  Signal_reset,
    input  logic [31:0]           Instr_in,
    input  logic                  Instr_valid,
    output logic                  Instr_ready,
    output logic [ADDR_WIDTH-1:0] Read_1,
    output logic [ADDR_WIDTH-1:0] Read_2,
    output logic                  Signal_read,
    input  logic [DATA_WIDTH-1:0] Out_1,
    input  logic [DATA_WIDTH-1:0] Out_2,
    output logic [ADDR_WIDTH-1:0] Address_to_write,
    output logic [DATA_WIDTH-1:0] Data_to_write,
    output logic                  Signal_write,
    output logic                  Done,
    output logic                  Error,
    output logic                  Zero,
    output logic                  Overflow
);

    state_e                state_q, state_d;
    logic [31:0]           instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  zero_q, zero_d;
    logic                  ovf_q, ovf_d;

    logic [3:0]            opcode;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_overflow;
    logic                  alu_illegal;

    assign opcode = instr_q[OPC_LSB +: 4];

    ula #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ula (
        .opcode_i  (opcode),
        .a_i       (Out_1),
        .b_i       (Out_2),
        .imm_i     (instr_q[IMM_LSB +: IMM_WIDTH]),
        .result_o  (alu_result),
        .overflow_o(alu_overflow),
        .illegal_o (alu_illegal)
    );

    always_ff @(posedge Clock_in) begin
        if (Signal_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        Instr_ready  = 1'b0;
        Signal_read  = 1'b0;
        Signal_write = 1'b0;
        Done         = 1'b0;
        Error        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                Instr_ready = 1'b1;
                if (Instr_valid) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                Signal_read = 1'b1;
                state_d     = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                Signal_write = writes_rd(opcode);
                Done         = 1'b1;
                Error        = alu_illegal;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The instruction is only replaced at accept, so the read addresses can be
    // taken straight from the latch and still hold between instructions.
    assign Read_1           = instr_q[RS1_LSB +: ADDR_WIDTH];
    assign Read_2           = instr_q[RS2_LSB +: ADDR_WIDTH];
    assign Address_to_write = waddr_q;
    assign Data_to_write    = wdata_q;
    assign Zero             = zero_q;
    assign Overflow         = ovf_q;

    always_comb begin
        instr_d = instr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        if (state_q == S_IDLE && Instr_valid) begin
            instr_d = Instr_in;
        end
        if (state_q == S_EXEC) begin
            waddr_d = instr_q[RD_LSB +: ADDR_WIDTH];
            wdata_d = alu_result;
            if (writes_rd(opcode)) begin
                zero_d = (alu_result == '0);
                ovf_d  = alu_overflow;
            end
        end
    end

    always_ff @(posedge Clock_in) begin
        if (Signal_reset) begin
            instr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/unidade_de_execucao.md
# unidade_de_execucao

Multi-cycle issue/execute/writeback sequencer sitting directly upstream and downstream of the 16×32 register bank. It accepts one instruction per handshake and drives the bank's read ports. It consumes the bank's registered `Out_1`/`Out_2`, computes the result in an ALU, and drives the bank's write port. Each instruction completes writeback before the next is accepted, so no hazard logic is needed.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `ADDR_WIDTH`, 4, register address width (16 registers)

Ports:
- `Clock_in` in 1: single clock; all state updates on rising edge
- `Signal_reset` in 1: reset, synchronous, active-high; shared with the register bank
- `Instr_in` in 32: instruction; `[31:28]` opcode, `[27:24]` rd, `[23:20]` rs1, `[19:16]` rs2, `[15:0]` imm
- `Instr_valid` in 1: instruction present
- `Instr_ready` out 1: combinational, equals (state == IDLE)
- `Read_1`, `Read_2` out ADDR_WIDTH: to bank read addresses
- `Signal_read` out 1: to bank read enable
- `Out_1`, `Out_2` in DATA_WIDTH: registered operands returned by the bank
- `Address_to_write` out ADDR_WIDTH: to bank write address
- `Data_to_write` out DATA_WIDTH: to bank write data
- `Signal_write` out 1: to bank write enable
- `Done` out 1: one-cycle pulse at writeback
- `Error` out 1: one-cycle pulse with `Done` on an illegal opcode
- `Zero` out 1: result == 0, held until next `Done`
- `Overflow` out 1: signed overflow of ADD/SUB/ADDI, held until next `Done`

## Operation
- **Opcodes:**
  - 0 NOP
  - 1 ADD rs1+rs2
  - 2 SUB rs1−rs2
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLL rs1<<rs2[4:0]
  - 7 SRL logical
  - 8 ADDI rs1+sext(imm)
  - 9 LUI imm<<16
  - A SLT (signed, result 1/0)
  - B–F illegal
- **Arithmetic:** modulo 2^32. Overflow is set when operand signs are equal (for SUB: differ) and the result sign differs; it is 0 for all other ops.
- **FSM:**
  - IDLE → READ on `Instr_valid && Instr_ready`. The instruction is latched on that edge.
  - READ → EXEC. During READ: `Signal_read`=1, `Read_1`=rs1, `Read_2`=rs2.
  - EXEC → WRITE. During EXEC the bank outputs are valid; the ALU result, Zero and Overflow are registered at the end of EXEC.
  - WRITE → IDLE. During WRITE: `Signal_write`=1 for writing opcodes, `Address_to_write`=rd, `Data_to_write`=result, `Done`=1.
- **NOP and illegal opcodes:** traverse all states with `Signal_write`=0. Illegal opcodes also pulse `Error`. Zero and Overflow are left unchanged.
- **rd:** any register, including 0 and 1, is writable.
- **Default output levels:** `Signal_read`, `Signal_write`, `Done` and `Error` are 0 outside the states listed above. `Read_*`, `Address_to_write` and `Data_to_write` hold their last values.

## Timing
- **Accept at edge E0:**
  - Read request in cycle E0+1.
  - Operands valid in cycle E0+2.
  - Write/Done in cycle E0+3; the bank is updated at the end of that cycle.
- **Throughput:** one instruction per 4 cycles. The next accept is at edge E0+4 at the earliest, and its read in E0+5 observes the prior write.
- **`Instr_valid` outside IDLE:** ignored; the upstream must hold the instruction until `Instr_ready`.
- **Reset values (in the cycle after a reset edge):** state IDLE; `Signal_read`, `Signal_write`, `Done`, `Error`, `Zero`, `Overflow` = 0; `Read_*`, `Address_to_write`, `Data_to_write` = 0.
- **Reset mid-operation:** any pending writeback is discarded, with no `Signal_write`/`Done` afterwards. The bank is reset by the same edge, so R1=1 and all other registers are 0.
- **Handshake during a reset cycle:** `Instr_ready`=1 is not an accept; reset has priority.

## Structure
- **Shared package:** opcode constants, instruction field bit positions, state encoding (IDLE, READ, EXEC, WRITE), `DATA_WIDTH`/`ADDR_WIDTH` defaults.
- **Sub-module `ula`:** combinational ALU with inputs opcode, a, b, imm and outputs result, overflow, illegal. `unidade_de_execucao` contains the FSM, the instruction latch and the output registers.

## Test plan
- Reset, then ADDI r2,r1,5 → exactly one `Signal_write` cycle with addr 2 and data 6; `Done`=1 three cycles after accept.
- Back-to-back ADD r3,r2,r2 then SUB r4,r1,r3 (`Instr_valid` held high) → r3=12, r4=0xFFFFFFF5; `Zero`=0; second accept exactly 4 cycles after first.
- LUI r5,0x7FFF then ADD r6,r5,r5 → r5=0x7FFF0000, r6=0xFFFE0000, `Overflow`=1; SUB r7,r6,r6 → 0, `Zero`=1, `Overflow`=0.
- Opcode 0xC → `Done`+`Error` pulse, no `Signal_write`, `Zero`/`Overflow` unchanged; NOP → `Done`, no `Error`, no write.
- Assert `Signal_reset` during the EXEC cycle of ADD r8,r1,r1 → no write or `Done` follows, `Instr_ready`=1, r8=0.
- SLL r9,r1,r10 with r10=31 → 0x80000000; SRL r9,r9,r10 → 1; SLT r11,r6,r1 → 1.
